// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states, wait-counter width.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Wide enough for WAIT_CYCLES up to 15.
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane handling for one memory word: load extraction/extension, store merge, format checks.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic        write,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic        fmt_err
);

  logic [3:0]  wmask;
  logic [31:0] wdata_sh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Decode funct3 into a load result or a byte-enable mask, flagging misaligned or illegal sizes.
  always_comb begin
    load_data  = '0;
    wmask      = '0;
    fmt_err    = 1'b0;
    lane_b     = rword[{addr_lo, 3'b000} +: 8];
    lane_h     = addr_lo[1] ? rword[31:16] : rword[15:0];
    wdata_sh   = wdata << {addr_lo, 3'b000};
    store_word = rword;
    if (write) begin
      case (funct3)
        F3_B: wmask = 4'b0001 << addr_lo;
        F3_H: begin
          wmask   = 4'b0011 << addr_lo;
          fmt_err = addr_lo[0];
        end
        F3_W: begin
          wmask   = 4'b1111;
          fmt_err = |addr_lo;
        end
        default: fmt_err = 1'b1;
      endcase
      if (fmt_err) wmask = '0;
    end else begin
      case (funct3)
        F3_B:  load_data = {{24{lane_b[7]}}, lane_b};
        F3_BU: load_data = {24'h0, lane_b};
        F3_H: begin
          load_data = {{16{lane_h[15]}}, lane_h};
          fmt_err   = addr_lo[0];
        end
        F3_HU: begin
          load_data = {16'h0, lane_h};
          fmt_err   = addr_lo[0];
        end
        F3_W: begin
          load_data = rword;
          fmt_err   = |addr_lo;
        end
        default: fmt_err = 1'b1;
      endcase
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (wmask[i]) store_word[8*i +: 8] = wdata_sh[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with fixed wait states and RV32I load/store alignment.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  mem_state_t            state, state_next;
  logic [WAIT_CNT_W-1:0] cnt;
  logic                  lat_write;
  logic [31:0]           lat_addr;
  logic [31:0]           lat_wdata;
  logic [2:0]            lat_funct3;

  logic                  accept;
  logic                  enter_resp;
  logic                  cur_write;
  logic [31:0]           cur_addr;
  logic [31:0]           cur_wdata;
  logic [2:0]            cur_funct3;
  logic [IDX_W-1:0]      idx;
  logic                  range_err;
  logic                  acc_err;
  logic [31:0]           rword;
  logic [31:0]           load_data;
  logic [31:0]           store_word;
  logic                  fmt_err;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the response is formed on the accept edge, so the
  // live request feeds the datapath in IDLE; otherwise the latched copy does.
  always_comb begin
    cur_write  = lat_write;
    cur_addr   = lat_addr;
    cur_wdata  = lat_wdata;
    cur_funct3 = lat_funct3;
    if (state == ST_IDLE) begin
      cur_write  = req_write;
      cur_addr   = req_addr;
      cur_wdata  = req_wdata;
      cur_funct3 = req_funct3;
    end
    range_err = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    idx       = cur_addr[IDX_W+1:2];
    rword     = mem[idx];
    acc_err   = fmt_err || range_err;
  end

  mem_lane_align u_align (
    .write      (cur_write),
    .addr_lo    (cur_addr[1:0]),
    .funct3     (cur_funct3),
    .wdata      (cur_wdata),
    .rword      (rword),
    .load_data  (load_data),
    .store_word (store_word),
    .fmt_err    (fmt_err)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic, handshake outputs and the "entering RESP" strobe.
  always_comb begin
    state_next = state;
    enter_resp = 1'b0;
    accept     = 1'b0;
    req_ready  = (state == ST_IDLE);
    rsp_valid  = (state == ST_RESP);
    case (state)
      ST_IDLE: begin
        accept = req_valid;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == WAIT_CNT_W'(WAIT_CYCLES - 1)) begin
          state_next = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        lat_write  <= req_write;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        lat_funct3 <= req_funct3;
      end
      if (state == ST_WAIT) cnt <= cnt + 1'b1;
      else                  cnt <= '0;
      if (enter_resp) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || cur_write) ? '0 : load_data;
      end else if (state == ST_RESP && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

  // Storage is never reset; a store commits only on a clean entry into RESP.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && cur_write && !acc_err) mem[idx] <= store_word;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a byte-level memory model.
module tb_data_mem_responder;

  localparam int unsigned W = 2;
  localparam int unsigned D = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [D];

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    logic        exp_err;
  } dop_t;

  dop_t dops [16];

  data_mem_responder #(.DEPTH_WORDS(D), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  // Reference: byte-addressed memory with RV32I size/sign rules.
  function automatic void model_apply(input logic wr, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [2:0] f3,
                                      output logic [31:0] rdata, output logic err);
    int unsigned off;
    int unsigned size;
    logic [31:0] word;
    logic [31:0] v;
    off   = int'(addr[1:0]);
    rdata = '0;
    err   = 1'b0;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (size == 0) err = 1'b1;
    if (wr && f3 > 3'd2) err = 1'b1;
    if (size > 1 && (off % size) != 0) err = 1'b1;
    if ({2'b00, addr[31:2]} >= 32'(D)) err = 1'b1;
    if (!err) begin
      word = model_mem[addr[11:2]];
      if (wr) begin
        for (int unsigned i = 0; i < size; i++) word[8*(off+i) +: 8] = wdata[8*i +: 8];
        model_mem[addr[11:2]] = word;
      end else begin
        v = word >> (8 * off);
        if (size == 1) begin
          v = v & 32'hFF;
          if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2) begin
          v = v & 32'hFFFF;
          if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        end
        rdata = v;
      end
    end
  endfunction

  // One complete transaction; latency counts post-edge samples from the accept edge (0 = timeout).
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                        output int latency);
    @(negedge clk);
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    latency = 0;
    for (int c = 1; c <= 50; c++) begin
      if (rsp_valid === 1'b1) begin
        latency = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_preload();
    logic [31:0] rd, erd, val;
    logic        er, eer;
    int          lat;
    for (int w = 0; w < 64; w++) begin
      val = (w == 8) ? 32'hCAFE_F00D : $urandom;
      model_apply(1'b1, 32'(w * 4), val, 3'b010, erd, eer);
      do_req(1'b1, 32'(w * 4), val, 3'b010, rd, er, lat);
      checks++;
      if (er !== 1'b0 || rd !== 32'h0 || lat != 1 + W) begin
        errors++;
        $display("FAIL preload[%0d]: got err=%b rdata=%h lat=%0d required 0 00000000 %0d",
                 w, er, rd, lat, 1 + W);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] rd, erd;
    logic        er, eer;
    int          lat;
    dops = '{
      '{1'b1, 32'h10,   32'hDEADBEEF, 3'b010, 32'h0,        1'b0},
      '{1'b0, 32'h10,   32'h0,        3'b010, 32'hDEADBEEF, 1'b0},
      '{1'b0, 32'h13,   32'h0,        3'b000, 32'hFFFFFFDE, 1'b0},
      '{1'b0, 32'h13,   32'h0,        3'b100, 32'h000000DE, 1'b0},
      '{1'b0, 32'h12,   32'h0,        3'b001, 32'hFFFFDEAD, 1'b0},
      '{1'b0, 32'h10,   32'h0,        3'b101, 32'h0000BEEF, 1'b0},
      '{1'b1, 32'h11,   32'h55,       3'b000, 32'h0,        1'b0},
      '{1'b0, 32'h10,   32'h0,        3'b010, 32'hDEAD55EF, 1'b0},
      '{1'b0, 32'h12,   32'h0,        3'b010, 32'h0,        1'b1},
      '{1'b1, 32'h11,   32'hAAAA,     3'b001, 32'h0,        1'b1},
      '{1'b0, 32'h10,   32'h0,        3'b010, 32'hDEAD55EF, 1'b0},
      '{1'b0, 32'h1000, 32'h0,        3'b010, 32'h0,        1'b1},
      '{1'b0, 32'h10,   32'h0,        3'b011, 32'h0,        1'b1},
      '{1'b1, 32'h10,   32'h0,        3'b100, 32'h0,        1'b1},
      '{1'b1, 32'h12,   32'h1234,     3'b001, 32'h0,        1'b0},
      '{1'b0, 32'h10,   32'h0,        3'b010, 32'h123455EF, 1'b0}
    };
    for (int i = 0; i < 16; i++) begin
      model_apply(dops[i].wr, dops[i].addr, dops[i].wdata, dops[i].f3, erd, eer);
      do_req(dops[i].wr, dops[i].addr, dops[i].wdata, dops[i].f3, rd, er, lat);
      checks++;
      if (rd !== dops[i].exp_rd || er !== dops[i].exp_err || lat != 1 + W) begin
        errors++;
        $display("FAIL directed[%0d]: got rdata=%h err=%b lat=%0d required %h %b %0d",
                 i, rd, er, lat, dops[i].exp_rd, dops[i].exp_err, 1 + W);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] erd, rd;
    logic        eer, er;
    int          lat;
    model_apply(1'b0, 32'h10, 32'h0, 3'b010, erd, eer);
    @(negedge clk);
    req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 50 && rsp_valid !== 1'b1; c++) begin
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_funct3 = 3'b010;
      req_valid = (k % 2 == 0);
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== erd || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b required 1 %h 0 0",
                 k, rsp_valid, rsp_rdata, rsp_err, req_ready, erd);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
        errors++;
        $display("FAIL backpressure_idle[%0d]: got valid=%b ready=%b rdata=%h required 0 1 00000000",
                 k, rsp_valid, req_ready, rsp_rdata);
      end
      @(posedge clk);
      #1;
    end
    do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    checks++;
    if (rd !== erd || er !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_nostore: got rdata=%h err=%b required %h 0", rd, er, erd);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rd, erd;
    logic        er, eer;
    int          lat;
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = 3'b010;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midflight_wait: got ready=%b valid=%b required 0 0", req_ready, rsp_valid);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL midflight_reset: got ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_apply(1'b0, 32'h20, 32'h0, 3'b010, erd, eer);
    do_req(1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat);
    checks++;
    if (rd !== erd || rd !== 32'hCAFE_F00D || er !== 1'b0 || lat != 1 + W) begin
      errors++;
      $display("FAIL midflight_contents: got rdata=%h err=%b lat=%0d required cafef00d 0 %0d",
               rd, er, lat, 1 + W);
    end
    // Reset while a response is being held must clear it at once.
    @(negedge clk);
    req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 50 && rsp_valid !== 1'b1; c++) begin
      @(posedge clk);
      #1;
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL resp_reset: got valid=%b rdata=%h ready=%b required 0 00000000 1",
               rsp_valid, rsp_rdata, req_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wdata;
    logic        er, eer, wr;
    logic [2:0]  f3;
    int          lat;
    for (int i = 0; i < 300; i++) begin
      wr    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      wdata = $urandom;
      if ($urandom_range(0, 7) == 0) addr = 32'h1000 + 32'($urandom_range(0, 4095));
      else                           addr = 32'($urandom_range(0, 255));
      model_apply(wr, addr, wdata, f3, erd, eer);
      do_req(wr, addr, wdata, f3, rd, er, lat);
      checks++;
      if (rd !== erd || er !== eer || lat != 1 + W) begin
        errors++;
        $display("FAIL random[%0d] wr=%b addr=%h f3=%0d: got rdata=%h err=%b lat=%0d required %h %b %0d",
                 i, wr, addr, f3, rd, er, lat, erd, eer, 1 + W);
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
